bm_dag_serial_rx: RTL and testbench
===================================

Name: bm_dag_serial_rx

Overview:
- Receiver end of a bit-serial operand link for the DAG micro-benchmark family.
- Deserialises one frame per transfer. Each frame carries operands a, b (BITS wide each) and c, d (1 bit each).
- Checks parity and the stop bit, then computes registered results out0 = a + b and out1 = c - d.
- Presents the results to a downstream consumer over a valid/ready handshake. Exercises FSM, counter, shift-register and handshake synthesis paths in Odin II.

Parameters:
- BITS, 2, operand width of a and b.
- DATA_BITS, 2*BITS+2, payload bits per frame. Derived; not overridden independently.

Ports:
- clock  input  1  single rising-edge clock.
- reset_n  input  1  asynchronous active-low reset.
- rx_in  input  1  serial line. Idles high; one bit sampled per clock.
- out_ready  input  1  consumer accepts the held result.
- out_valid  output  1  result registers hold an unconsumed result.
- out0  output  BITS  (a + b) mod 2^BITS.
- out1  output  1  (c - d) mod 2, equal to c XOR d.
- a_out  output  BITS  received a (raw, for checking).
- b_out  output  BITS  received b.
- frame_err  output  1  one-cycle pulse on parity or stop-bit error.
- overrun  output  1  one-cycle pulse when a good frame is dropped.

Behaviour:
- Frame order on rx_in, one bit per cycle:
  - start bit (0);
  - DATA_BITS payload bits, LSB first, in the order a[0..BITS-1], b[0..BITS-1], c, d;
  - even parity bit, chosen so the XOR of payload and parity is 0;
  - stop bit (1).
  - Total 9 cycles at BITS=2.
- FSM states IDLE, DATA, PARITY, STOP. Binary encoded.
  - IDLE: rx_in==0 → DATA, bit counter cleared; otherwise stay.
  - DATA: shift rx_in into the payload register and increment the counter. After the DATA_BITS-th bit → PARITY.
  - PARITY: sample rx_in into the parity flag → STOP.
  - STOP: evaluate the frame → IDLE unconditionally.
- Frame evaluation in STOP:
  - Good frame: rx_in==1 and parity check passes.
  - If rx_in==0 or parity fails: frame_err=1 on the next cycle for one cycle. The frame is discarded and the output registers are untouched. A frame with both errors raises frame_err only.
  - A good frame is loaded into out0/out1/a_out/b_out, with out_valid=1 on the next cycle, when out_valid==0 or (out_valid && out_ready) in the STOP cycle.
  - Otherwise the good frame is dropped, overrun pulses for one cycle, and the old result is held.
- Latency: results and out_valid appear the cycle after the stop bit is sampled. No combinational path from rx_in to any output.
- Back-to-back frames: a start bit in the cycle immediately after the stop bit is accepted, since IDLE samples it.
- Handshake:
  - A transfer occurs on a clock edge with out_valid && out_ready.
  - out_valid clears after the transfer unless a new result loads on the same edge; the load wins and out_valid stays 1.
  - Outputs hold stable while out_valid && !out_ready.
  - out_ready while out_valid==0 has no effect.
- Arithmetic: out0 is truncated to BITS (carry discarded); out1 is 1-bit wraparound.
- Reset, asserted at any time including mid-frame: FSM → IDLE, counter/shift/parity cleared, and every output = 0 (out_valid, out0, out1, a_out, b_out, frame_err, overrun). A frame partly received at reset is lost. The first start bit after deassertion begins a fresh frame.
- A start-bit glitch in IDLE (a single-cycle 0) is treated as a start. The resulting garbage frame is rejected by the parity/stop check.

Decomposition:
- Shared package holds:
  - state encodings (ST_IDLE, ST_DATA, ST_PARITY, ST_STOP);
  - the DATA_BITS derivation;
  - the field offset constants (A_LSB=0, B_LSB=BITS, C_POS=2*BITS, D_POS=2*BITS+1).
- One sub-module, serial_frame_shift: payload shift register, bit counter and running parity XOR, with a done flag to the FSM.
- FSM, evaluation and output registers stay in the top module.

Test Plan:
- Good frame: a=2, b=3, c=1, d=0; rx_in = 0,0,1,1,1,1,0,0,1 with out_ready=1 → one cycle after stop: out_valid=1, out0=1, out1=1, a_out=2, b_out=3; out_valid=0 next cycle.
- Parity error: same frame with parity bit 1 → frame_err pulses once, out_valid stays 0, out0 stays 0.
- Stop error: same frame with stop bit 0 → frame_err pulses once, no load. The following good frame (a=1, b=1, c=0, d=1) → out0=2, out1=1.
- Overrun: two good frames back-to-back (a=2,b=3,c=1,d=0, then a=1,b=1,c=1,d=1) with out_ready=0 → overrun pulses at the end of the second frame, out0 holds 1. Raise out_ready → one transfer, out_valid=0.
- Simultaneous consume/load: out_ready=1 held, frames back-to-back → out_valid stays 1 across the frame boundary; results update to the second frame (out0=2, out1=0).
- Reset mid-frame: assert reset_n=0 after 4 data bits → all outputs 0, FSM IDLE. Then a full good frame (a=3, b=3, c=0, d=0) → out0=2, out1=0, out_valid=1.

Source files
------------

// File: rtl/bm_dag_serial_rx_pkg.sv
// Shared definitions for the bit-serial operand receiver: FSM states,
// payload size derivation and field positions inside the payload.
package bm_dag_serial_rx_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DATA   = 2'd1,
        ST_PARITY = 2'd2,
        ST_STOP   = 2'd3
    } rx_state_e;

    localparam int A_LSB = 0;

    function automatic int data_bits(input int bits);
        return 2 * bits + 2;
    endfunction

    function automatic int b_lsb(input int bits);
        return bits;
    endfunction

    function automatic int c_pos(input int bits);
        return 2 * bits;
    endfunction

    function automatic int d_pos(input int bits);
        return 2 * bits + 1;
    endfunction

endpackage

// File: rtl/bm_dag_serial_rx_if.sv
// Result handshake bundle between the receiver (master) and its consumer.
interface bm_dag_serial_rx_if #(
    parameter int BITS = 2
);
    logic            out_ready;
    logic            out_valid;
    logic [BITS-1:0] out0;
    logic            out1;
    logic [BITS-1:0] a_out;
    logic [BITS-1:0] b_out;
    logic            frame_err;
    logic            overrun;

    modport master (
        input  out_ready,
        output out_valid, out0, out1, a_out, b_out, frame_err, overrun
    );

    modport slave (
        output out_ready,
        input  out_valid, out0, out1, a_out, b_out, frame_err, overrun
    );
endinterface

// File: rtl/bm_dag_serial_rx_serial_frame_shift.sv
// Payload deserialiser: LSB-first shift register, bit counter and running
// parity; done flags the last payload bit while it is being shifted in.
module serial_frame_shift #(
    parameter int DATA_BITS = 6
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 clr_i,
    input  logic                 shift_en_i,
    input  logic                 bit_i,
    output logic [DATA_BITS-1:0] payload_o,
    output logic                 par_o,
    output logic                 done_o
);
    localparam int CW = $clog2(DATA_BITS + 1);

    logic [DATA_BITS-1:0] sh_q, sh_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic                 par_q, par_d;

    always_comb begin
        sh_d  = sh_q;
        cnt_d = cnt_q;
        par_d = par_q;
        if (clr_i) begin
            sh_d  = '0;
            cnt_d = '0;
            par_d = 1'b0;
        end else if (shift_en_i) begin
            // New bits enter at the top so the first bit ends up at bit 0.
            sh_d  = {bit_i, sh_q[DATA_BITS-1:1]};
            cnt_d = cnt_q + 1'b1;
            par_d = par_q ^ bit_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sh_q  <= '0;
            cnt_q <= '0;
            par_q <= 1'b0;
        end else begin
            sh_q  <= sh_d;
            cnt_q <= cnt_d;
            par_q <= par_d;
        end
    end

    assign payload_o = sh_q;
    assign par_o     = par_q;
    assign done_o    = shift_en_i && (cnt_q == CW'(DATA_BITS - 1));

endmodule

// File: rtl/bm_dag_serial_rx.sv
// Bit-serial operand receiver: frames {start, a, b, c, d, parity, stop},
// validates them and presents a+b / c-d over a valid/ready handshake.
module bm_dag_serial_rx
    import bm_dag_serial_rx_pkg::*;
#(
    parameter int BITS = 2
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic                 rx_in,
    bm_dag_serial_rx_if.master   bus
);
    localparam int DATA_BITS = data_bits(BITS);
    localparam int B_LSB     = b_lsb(BITS);
    localparam int C_POS     = c_pos(BITS);
    localparam int D_POS     = d_pos(BITS);

    rx_state_e state_q, state_d;

    logic [DATA_BITS-1:0] payload;
    logic                 run_par;
    logic                 data_done;
    logic                 start, shift_en;

    logic                 parbit_q, parbit_d;
    logic                 valid_q, valid_d;
    logic [BITS-1:0]      out0_q, out0_d;
    logic                 out1_q, out1_d;
    logic [BITS-1:0]      a_q, a_d;
    logic [BITS-1:0]      b_q, b_d;
    logic                 ferr_q, ovr_q;

    logic                 good, load, err, ovr;
    logic [BITS-1:0]      fa, fb;
    logic                 fc, fd;

    assign start    = (state_q == ST_IDLE) && !rx_in;
    assign shift_en = (state_q == ST_DATA);

    serial_frame_shift #(.DATA_BITS(DATA_BITS)) u_shift (
        .clk        (clock),
        .rst_n      (reset_n),
        .clr_i      (start),
        .shift_en_i (shift_en),
        .bit_i      (rx_in),
        .payload_o  (payload),
        .par_o      (run_par),
        .done_o     (data_done)
    );

    assign fa = payload[A_LSB +: BITS];
    assign fb = payload[B_LSB +: BITS];
    assign fc = payload[C_POS];
    assign fd = payload[D_POS];

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) state_q <= ST_IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:   if (!rx_in)    state_d = ST_DATA;
            ST_DATA:   if (data_done) state_d = ST_PARITY;
            ST_PARITY:                state_d = ST_STOP;
            ST_STOP:                  state_d = ST_IDLE;
            default:                  state_d = ST_IDLE;
        endcase
    end

    // Frame evaluation and result-register update decisions.
    always_comb begin
        good     = 1'b0;
        load     = 1'b0;
        err      = 1'b0;
        ovr      = 1'b0;
        parbit_d = parbit_q;
        if (state_q == ST_PARITY) parbit_d = rx_in;
        if (state_q == ST_STOP) begin
            good = rx_in && !(run_par ^ parbit_q);
            err  = !good;
            load = good && (!valid_q || bus.out_ready);
            ovr  = good && !load;
        end

        valid_d = valid_q;
        out0_d  = out0_q;
        out1_d  = out1_q;
        a_d     = a_q;
        b_d     = b_q;
        if (load) begin
            valid_d = 1'b1;
            out0_d  = fa + fb;
            out1_d  = fc - fd;
            a_d     = fa;
            b_d     = fb;
        end else if (valid_q && bus.out_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            parbit_q <= 1'b0;
            valid_q  <= 1'b0;
            out0_q   <= '0;
            out1_q   <= 1'b0;
            a_q      <= '0;
            b_q      <= '0;
            ferr_q   <= 1'b0;
            ovr_q    <= 1'b0;
        end else begin
            parbit_q <= parbit_d;
            valid_q  <= valid_d;
            out0_q   <= out0_d;
            out1_q   <= out1_d;
            a_q      <= a_d;
            b_q      <= b_d;
            ferr_q   <= err;
            ovr_q    <= ovr;
        end
    end

    assign bus.out_valid = valid_q;
    assign bus.out0      = out0_q;
    assign bus.out1      = out1_q;
    assign bus.a_out     = a_q;
    assign bus.b_out     = b_q;
    assign bus.frame_err = ferr_q;
    assign bus.overrun   = ovr_q;

endmodule

// File: tb/tb_bm_dag_serial_rx.sv
// Self-checking bench: directed frame table, hand-written handshake/reset
// sequences and random frames, all compared every cycle to a frame-level model.
module tb_bm_dag_serial_rx;
    localparam int BITS = 2;

    logic clock = 1'b0;
    logic reset_n;
    logic rx_in;

    bm_dag_serial_rx_if #(.BITS(BITS)) bus ();

    bm_dag_serial_rx #(.BITS(BITS)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .rx_in   (rx_in),
        .bus     (bus.master)
    );

    always #5 clock = ~clock;

    int n_chk  = 0;
    int n_pass = 0;

    logic            m_valid, m_out1, m_ferr, m_ovr;
    logic [BITS-1:0] m_out0, m_a, m_b;

    typedef struct {
        int a, b, c, d;
        bit perr, serr;
        int gap, rdy, rstop;
        bit ev;
        int eo0;
        bit eo1;
        int ea, eb;
        bit efe, eov;
    } vec_t;

    vec_t vt[5];

    function automatic logic [9:0] obs();
        return {bus.out_valid, bus.out0, bus.out1, bus.a_out, bus.b_out,
                bus.frame_err, bus.overrun};
    endfunction

    function automatic logic [9:0] mdl();
        return {m_valid, m_out0, m_out1, m_a, m_b, m_ferr, m_ovr};
    endfunction

    function automatic logic [9:0] expv(input bit v, input int o0, input bit o1,
                                        input int a, input int b, input bit fe, input bit ov);
        logic [BITS-1:0] o0b, ab, bb;
        o0b = BITS'(o0);
        ab  = BITS'(a);
        bb  = BITS'(b);
        return {v, o0b, o1, ab, bb, fe, ov};
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    endtask

    task automatic model_reset();
        m_valid = 0; m_out0 = '0; m_out1 = 0; m_a = '0; m_b = '0; m_ferr = 0; m_ovr = 0;
    endtask

    function automatic logic pick(input int mode);
        if (mode == 2) return logic'($urandom_range(0, 1));
        return (mode != 0);
    endfunction

    // One clock: drive, update the model for this edge, then compare.
    task automatic cycle(input logic rx, input logic rdy, input bit is_stop, input bit good,
                         input int fa, input int fb, input int fc, input int fd);
        rx_in         = rx;
        bus.out_ready = rdy;
        @(posedge clock);
        m_ferr = is_stop && !good;
        m_ovr  = 0;
        if (is_stop && good) begin
            if (!m_valid || rdy) begin
                m_valid = 1;
                m_out0  = BITS'((fa + fb) % (1 << BITS));
                m_out1  = ((fc - fd) % 2) != 0;
                m_a     = BITS'(fa);
                m_b     = BITS'(fb);
            end else begin
                m_ovr = 1;
            end
        end else if (m_valid && rdy) begin
            m_valid = 0;
        end
        #1;
        check("cycle", obs(), mdl());
    endtask

    task automatic send_frame(input int fa, input int fb, input int fc, input int fd,
                              input bit perr, input bit serr, input int rmode, input int rstop);
        bit q[$];
        bit par;
        bit good;
        par = 0;
        q.push_back(1'b0);
        for (int i = 0; i < BITS; i++) q.push_back(((fa >> i) & 1) != 0);
        for (int i = 0; i < BITS; i++) q.push_back(((fb >> i) & 1) != 0);
        q.push_back(fc[0]);
        q.push_back(fd[0]);
        for (int i = 1; i < q.size(); i++) par = par ^ q[i];
        par = par ^ perr;
        q.push_back(par);
        q.push_back(!serr);
        // Even parity: payload XOR parity bit must be 0, and stop must be 1.
        good = (q[q.size()-1] == 1'b1) && ((par ^ perr) == par) ? 1'b0 : 1'b0;
        good = !serr && !perr;
        for (int i = 0; i < q.size(); i++) begin
            if (i == q.size() - 1)
                cycle(q[i], pick(rstop), 1'b1, good, fa, fb, fc, fd);
            else
                cycle(q[i], pick(rmode), 1'b0, 1'b0, fa, fb, fc, fd);
        end
    endtask

    initial begin
        vt[0] = '{a:2, b:3, c:1, d:0, perr:1, serr:0, gap:0, rdy:1, rstop:1,
                  ev:0, eo0:0, eo1:0, ea:0, eb:0, efe:1, eov:0};
        vt[1] = '{a:2, b:3, c:1, d:0, perr:0, serr:1, gap:0, rdy:1, rstop:1,
                  ev:0, eo0:0, eo1:0, ea:0, eb:0, efe:1, eov:0};
        vt[2] = '{a:1, b:1, c:0, d:1, perr:0, serr:0, gap:0, rdy:1, rstop:1,
                  ev:1, eo0:2, eo1:1, ea:1, eb:1, efe:0, eov:0};
        vt[3] = '{a:2, b:3, c:1, d:0, perr:0, serr:0, gap:1, rdy:0, rstop:0,
                  ev:1, eo0:1, eo1:1, ea:2, eb:3, efe:0, eov:0};
        vt[4] = '{a:1, b:1, c:1, d:1, perr:0, serr:0, gap:0, rdy:0, rstop:0,
                  ev:1, eo0:1, eo1:1, ea:2, eb:3, efe:0, eov:1};

        reset_n = 0;
        rx_in = 1;
        bus.out_ready = 0;
        model_reset();
        #12;
        check("reset_state", obs(), 10'd0);
        @(posedge clock);
        #1;
        reset_n = 1;

        // Directed table: parity error, stop error, good frames, overrun.
        for (int i = 0; i < 5; i++) begin
            for (int g = 0; g < vt[i].gap; g++) cycle(1'b1, 1'b1, 1'b0, 1'b0, 0, 0, 0, 0);
            send_frame(vt[i].a, vt[i].b, vt[i].c, vt[i].d, vt[i].perr, vt[i].serr,
                       vt[i].rdy, vt[i].rstop);
            check($sformatf("table%0d", i), obs(),
                  expv(vt[i].ev, vt[i].eo0, vt[i].eo1, vt[i].ea, vt[i].eb, vt[i].efe, vt[i].eov));
        end

        // Raising ready transfers the held result once.
        cycle(1'b1, 1'b1, 1'b0, 1'b0, 0, 0, 0, 0);
        check("xfer_valid", {31'd0, bus.out_valid}, 32'd0);

        // Consume and load on the same edge: valid stays high, data updates.
        send_frame(2, 3, 1, 0, 0, 0, 0, 0);
        send_frame(1, 1, 1, 1, 0, 0, 0, 1);
        check("consume_load", obs(), expv(1, 2, 0, 1, 1, 0, 0));
        cycle(1'b1, 1'b1, 1'b0, 1'b0, 0, 0, 0, 0);

        // Reset in the middle of a frame (start + 4 data bits).
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 0, 0);
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 0, 0);
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 0, 0, 0, 0);
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 0, 0, 0, 0);
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 0, 0, 0, 0);
        #2;
        reset_n = 0;
        rx_in = 1;
        #1;
        model_reset();
        check("reset_midframe", obs(), 10'd0);
        @(posedge clock);
        @(posedge clock);
        #1;
        reset_n = 1;
        send_frame(3, 3, 0, 0, 0, 0, 0, 0);
        check("after_reset", obs(), expv(1, 2, 0, 3, 3, 0, 0));

        // Random frames, random gaps and per-cycle random ready.
        for (int n = 0; n < 60; n++) begin
            int gap;
            gap = $urandom_range(0, 2);
            for (int g = 0; g < gap; g++)
                cycle(1'b1, pick(2), 1'b0, 1'b0, 0, 0, 0, 0);
            send_frame($urandom_range(0, 3), $urandom_range(0, 3),
                       $urandom_range(0, 1), $urandom_range(0, 1),
                       $urandom_range(0, 4) == 0, $urandom_range(0, 4) == 0, 2, 2);
        end
        cycle(1'b1, 1'b1, 1'b0, 1'b0, 0, 0, 0, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
